apu_audio_decimator: RTL and testbench

Upstream audio stage feeding the codec serializer: takes the NES APU mixed sample stream (arbitrary-rate strobes in the 18.432 MHz domain), box-car averages it over one 48 kHz output period, and buffers the results in a small FIFO. The serializer pulls words with its `audio_fifo_rdreq` / `audio_fifo_data` pair. Output words are 16-bit two's complement, held stable for a full frame.

---
 rtl/audio_pkg.sv | 23 ++
 rtl/audio_sample_fifo.sv | 73 +++++++
 rtl/apu_audio_decimator.sv | 136 +++++++++++++
 tb/tb_apu_audio_decimator.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared constants and types for the APU audio decimation path.
//   REF_CLK_HZ / AUDIO_SAMPLE_RATE : default clock and output rate
//   AUDIO_WINDOW                   : reference cycles per output sample
//   AUDIO_RECIP                    : round(2^24 / window), the scaling multiplier
//   audio_sample_t                 : signed 16-bit audio word
package audio_pkg;

    localparam int REF_CLK_HZ        = 18432000;
    localparam int AUDIO_SAMPLE_RATE = 48000;
    localparam int ACC_W             = 25;
    localparam int RECIP_SHIFT       = 24;

    // Rounded fixed-point reciprocal so the average needs a multiply, not a divide.
    function automatic int calc_recip(input int window);
        return ((1 << RECIP_SHIFT) + window / 2) / window;
    endfunction

    localparam int AUDIO_WINDOW = REF_CLK_HZ / AUDIO_SAMPLE_RATE;
    localparam int AUDIO_RECIP  = calc_recip(AUDIO_WINDOW);

    typedef logic signed [15:0] audio_sample_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Register-array FIFO for decimated audio words.
//   clk, reset     : clock, asynchronous active-low reset
//   push/push_data : write request and word; dropped when full unless a pop
//                    happens in the same cycle
//   pop            : one-cycle read request; on empty it only flags underflow
//   pop_data       : last word read, changes only on a successful pop
//   level          : registered number of stored words
//   overflow       : one-cycle pulse when a push was dropped
//   underflow      : one-cycle pulse when a pop hit an empty FIFO
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  audio_sample_t push_data,
    input  logic          pop,
    output audio_sample_t pop_data,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic          underflow
);

    audio_sample_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          pop_ok;
    logic          push_ok;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            pop_data  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= push && !push_ok;
            underflow <= pop && empty;
            if (pop_ok) begin
                pop_data <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + AW'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/apu_audio_decimator.sv
// Box-car decimator from the APU mixer stream to 48 kHz signed words, with an
// output FIFO read by the codec serializer.
// Optional feature macro: APU_AUDIO_SIGNED_CONV_EN
//   defined   : sample_in MSB is inverted on capture (unsigned -> two's complement)
//   undefined : sample_in is already two's complement and is used as is
// Ports:
//   clk, reset       : system clock, asynchronous active-low reset
//   sample_in        : mixer sample, valid when sample_valid is high
//   sample_valid     : one-cycle capture strobe
//   audio_fifo_rdreq : serializer read request (level; each rising edge pops once)
//   audio_fifo_data  : current output word, updated only by a successful pop
//   fifo_level       : words stored
//   overflow         : pulse when a result is dropped on a full FIFO
//   underflow        : pulse when a pop is attempted on an empty FIFO
module apu_audio_decimator
    import audio_pkg::*;
#(
    parameter int REF_CLK     = REF_CLK_HZ,
    parameter int SAMPLE_RATE = AUDIO_SAMPLE_RATE,
    parameter int DEPTH       = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              sample_in,
    input  logic                     sample_valid,
    input  logic                     audio_fifo_rdreq,
    output logic [15:0]              audio_fifo_data,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int W      = REF_CLK / SAMPLE_RATE;
    localparam int RECIP  = calc_recip(W);
    localparam int WCNT_W = $clog2(W);
    localparam int PROD_W = ACC_W + 18;
    localparam int SW     = PROD_W - RECIP_SHIFT;
    localparam logic [WCNT_W-1:0]  WCNT_LAST = WCNT_W'(W - 1);
    localparam logic signed [SW-1:0] SAT_MAX = SW'(32767);
    localparam logic signed [SW-1:0] SAT_MIN = SW'(-32768);

    audio_sample_t           conv;
    audio_sample_t           cur;
    audio_sample_t           held;
    logic [WCNT_W-1:0]       wcnt;
    logic                    window_end;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] acc_q;
    logic                    acc_vld;
    logic signed [SW-1:0]    scaled;
    audio_sample_t           avg_next;
    audio_sample_t           avg;
    logic                    avg_vld;
    logic                    rdreq_prev;
    logic                    pop_req;
    audio_sample_t           fifo_dout;

`ifdef APU_AUDIO_SIGNED_CONV_EN
    assign conv = {~sample_in[15], sample_in[14:0]};
`else
    assign conv = sample_in;
`endif

    // A strobed sample counts in the very cycle it arrives.
    assign cur        = sample_valid ? conv : held;
    assign acc_next   = acc + ACC_W'(cur);
    assign window_end = (wcnt == WCNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            held    <= '0;
            wcnt    <= '0;
            acc     <= '0;
            acc_q   <= '0;
            acc_vld <= 1'b0;
        end else begin
            held    <= cur;
            acc_vld <= window_end;
            if (window_end) begin
                wcnt  <= '0;
                acc   <= '0;
                acc_q <= acc_next;
            end else begin
                wcnt <= wcnt + WCNT_W'(1);
                acc  <= acc_next;
            end
        end
    end

    // Multiply by the rounded reciprocal; the arithmetic shift floors toward -inf.
    assign scaled = SW'((PROD_W'(acc_q) * PROD_W'(RECIP)) >>> RECIP_SHIFT);

    always_comb begin
        avg_next = scaled[15:0];
        if (scaled > SAT_MAX) begin
            avg_next = 16'sh7FFF;
        end else if (scaled < SAT_MIN) begin
            avg_next = 16'sh8000;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            avg        <= '0;
            avg_vld    <= 1'b0;
            rdreq_prev <= 1'b0;
            pop_req    <= 1'b0;
        end else begin
            avg_vld    <= acc_vld;
            if (acc_vld) begin
                avg <= avg_next;
            end
            // Registered rising-edge detect: a long request level pops once.
            rdreq_prev <= audio_fifo_rdreq;
            pop_req    <= audio_fifo_rdreq && !rdreq_prev;
        end
    end

    audio_sample_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (avg_vld),
        .push_data (avg),
        .pop       (pop_req),
        .pop_data  (fifo_dout),
        .level     (fifo_level),
        .overflow  (overflow),
        .underflow (underflow)
    );

    assign audio_fifo_data = fifo_dout;

endmodule

// File: tb/tb_apu_audio_decimator.sv
module tb_apu_audio_decimator;

    localparam int     W     = 384;
    localparam int     DEPTH = 16;
    localparam longint RECIP = 43691;
`ifdef APU_AUDIO_SIGNED_CONV_EN
    localparam logic [15:0] FLIP = 16'h8000;
`else
    localparam logic [15:0] FLIP = 16'h0000;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] sample_in = 16'h0000;
    logic        sample_valid = 1'b0;
    logic        audio_fifo_rdreq = 1'b0;
    logic [15:0] audio_fifo_data;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic        underflow;

    int n_cmp = 0;
    int n_bad = 0;
    int n_ovf = 0;

    always #5 clk = ~clk;

    apu_audio_decimator #(
        .REF_CLK     (18432000),
        .SAMPLE_RATE (48000),
        .DEPTH       (DEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .sample_in        (sample_in),
        .sample_valid     (sample_valid),
        .audio_fifo_rdreq (audio_fifo_rdreq),
        .audio_fifo_data  (audio_fifo_data),
        .fifo_level       (fifo_level),
        .overflow         (overflow),
        .underflow        (underflow)
    );

    // ---------------- behavioural model ----------------
    typedef struct {
        int due;
        int val;
    } push_t;

    int    cyc = 0;
    int    held_m = 0;
    longint wsum = 0;
    int    wpos = 0;
    logic  prev_rq = 1'b0;
    int    pop_due = -1;
    int    q[$];
    push_t pend[$];
    int    exp_data = 0;
    int    exp_ovf = 0;
    int    exp_udf = 0;

    function automatic int scale(input longint s);
        longint a;
        a = (s * RECIP) >>> 24;
        if (a > 32767) return 32767;
        if (a < -32768) return -32768;
        return int'(a);
    endfunction

    function automatic int sdata();
        return int'($signed(audio_fifo_data));
    endfunction

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            cyc = 0; held_m = 0; wsum = 0; wpos = 0; prev_rq = 1'b0;
            pop_due = -1; q.delete(); pend.delete();
            exp_data = 0; exp_ovf = 0; exp_udf = 0;
        end else begin
            exp_ovf = 0;
            exp_udf = 0;
            if (pop_due == cyc) begin
                if (q.size() > 0) exp_data = q.pop_front();
                else exp_udf = 1;
            end
            if (pend.size() > 0 && pend[0].due == cyc) begin
                push_t p;
                p = pend.pop_front();
                if (q.size() < DEPTH) q.push_back(p.val);
                else exp_ovf = 1;
            end
            if (sample_valid) held_m = int'($signed(sample_in ^ FLIP));
            wsum += longint'(held_m);
            wpos++;
            if (wpos == W) begin
                pend.push_back('{due: cyc + 2, val: scale(wsum)});
                wsum = 0;
                wpos = 0;
            end
            if (audio_fifo_rdreq && !prev_rq) pop_due = cyc + 1;
            prev_rq = audio_fifo_rdreq;
            cyc++;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp, input int tol);
        n_cmp++;
        if (act > exp + tol || act < exp - tol) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (reset) begin
            check("data", sdata(), exp_data, 0);
            check("level", int'(fifo_level), q.size(), 0);
            check("ovf", int'(overflow), exp_ovf, 0);
            check("udf", int'(underflow), exp_udf, 0);
        end
    end

    initial forever begin
        @(negedge clk);
        if (reset && overflow) n_ovf++;
    end

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    task automatic apply_reset(input logic [15:0] sv);
        @(negedge clk);
        reset = 1'b0;
        audio_fifo_rdreq = 1'b0;
        sample_in = sv ^ FLIP;
        sample_valid = 1'b1;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_sample(input logic [15:0] sv);
        sample_in = sv ^ FLIP;
    endtask

    task automatic strobe(input logic [15:0] sv);
        sample_in = sv ^ FLIP;
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        sample_in = 16'h5A5A;
    endtask

    task automatic pop_at(input int c);
        goto(c);
        audio_fifo_rdreq = 1'b1;
        goto(c + 1);
        audio_fifo_rdreq = 1'b0;
    endtask

    initial begin
        // first-word latency and value
        apply_reset(16'h1000);
        @(negedge clk);
        check("reset_level", int'(fifo_level), 0, 0);
        check("reset_data", sdata(), 0, 0);
        goto(W + 1); @(negedge clk);
        check("a_level_t2", int'(fifo_level), 0, 0);
        goto(W + 2); @(negedge clk);
        check("a_level_t3", int'(fifo_level), 1, 0);
        pop_at(W + 2);
        goto(W + 4); @(negedge clk);
        check("a_first_word", sdata(), 4096, 1);

        // saturation at both rails
        apply_reset(16'h7FFF);
        goto(W); set_sample(16'h8000);
        pop_at(W + 2);
        goto(W + 4); @(negedge clk);
        check("b_sat_hi", sdata(), 32767, 0);
        pop_at(2 * W + 2);
        goto(2 * W + 4); @(negedge clk);
        check("b_sat_lo", sdata(), -32768, 0);

        // held value between sparse strobes, +/- half windows cancel
        goto(3 * W); strobe(16'h2000);
        pop_at(3 * W + 2);
        goto(3 * W + 4); @(negedge clk);
        check("c_prev_window", sdata(), -32768, 0);
        goto(3 * W + W / 2); strobe(16'hE000);
        pop_at(4 * W + 2);
        goto(4 * W + 4); @(negedge clk);
        check("c_balanced", sdata(), 0, 1);

        // mid-window reset, long request, underflow, push+pop on empty
        apply_reset(16'h0200);
        goto(W);     set_sample(16'h0300);
        goto(2 * W); set_sample(16'h0400);
        goto(3 * W); set_sample(16'h0500);
        goto(3 * W + 2); @(negedge clk);
        check("d_level3", int'(fifo_level), 3, 0);
        audio_fifo_rdreq = 1'b1;
        goto(3 * W + 14);
        audio_fifo_rdreq = 1'b0;
        goto(3 * W + 15); @(negedge clk);
        check("d_hold_level", int'(fifo_level), 2, 0);
        check("d_hold_data", sdata(), 16'h0200, 0);
        pop_at(3 * W + 20);
        pop_at(3 * W + 25);
        goto(3 * W + 27); @(negedge clk);
        check("d_drained", int'(fifo_level), 0, 0);
        pop_at(3 * W + 30);
        goto(3 * W + 32); @(negedge clk);
        check("d_udf", int'(underflow), 1, 0);
        check("d_udf_data", sdata(), 16'h0400, 0);
        pop_at(4 * W);
        goto(4 * W + 2); @(negedge clk);
        check("d_empty_pp_udf", int'(underflow), 1, 0);
        check("d_empty_pp_level", int'(fifo_level), 1, 0);
        check("d_empty_pp_data", sdata(), 16'h0400, 0);

        // overflow and push+pop on full
        apply_reset(16'h0100);
        n_ovf = 0;
        for (int w = 1; w <= 16; w++) begin
            goto(w * W);
            set_sample(16'(w + 1) << 8);
        end
        goto(16 * W + 2); @(negedge clk);
        check("e_full", int'(fifo_level), 16, 0);
        goto(17 * W); set_sample(16'h1200);
        goto(17 * W + 2); @(negedge clk);
        check("e_ovf", int'(overflow), 1, 0);
        check("e_ovf_level", int'(fifo_level), 16, 0);
        pop_at(17 * W + 5);
        goto(17 * W + 7); @(negedge clk);
        check("e_oldest", sdata(), 16'h0100, 0);
        check("e_level15", int'(fifo_level), 15, 0);
        goto(18 * W); set_sample(16'h1300);
        goto(18 * W + 2); @(negedge clk);
        check("e_refill", int'(fifo_level), 16, 0);
        pop_at(19 * W);
        goto(19 * W + 2); @(negedge clk);
        check("e_full_pp_level", int'(fifo_level), 16, 0);
        check("e_full_pp_ovf", int'(overflow), 0, 0);
        check("e_full_pp_data", sdata(), 16'h0200, 0);
        check("e_ovf_count", n_ovf, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
